// File: rtl/opti_pkg.sv
// Shared types, constants, coefficients and round/saturate helper for the
// 6th-order fixed-point IIR low-pass filter (three DF-I biquads, Q2.22).
package opti_pkg;

    localparam int DATA_W       = 24;
    localparam int FRAC_W       = 22;
    localparam int ACC_W        = 51;
    localparam int PROD_W       = 2 * DATA_W;
    localparam int SHR_W        = ACC_W - FRAC_W;
    localparam int NUM_SECTIONS = 3;
    localparam int N_SAMPLES    = 2048;
    localparam int ADDR_W       = $clog2(N_SAMPLES);
    localparam int INIT_CYCLES  = 4;
    localparam int INIT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } state_e;

    // Per section: b0, b1, b2, a1, a2 in Q2.22; every section has unity DC gain.
    localparam logic signed [DATA_W-1:0] COEF [NUM_SECTIONS][5] = '{
        '{24'sd262144,  24'sd524288,  24'sd262144,  -24'sd4194304, 24'sd1048576},
        '{24'sd524288,  24'sd1048576, 24'sd524288,  -24'sd3145728, 24'sd1048576},
        '{24'sd1048576, 24'sd2097152, 24'sd1048576, -24'sd2097152, 24'sd2097152}
    };

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [SHR_W-1:0] SAT_MAX  = SHR_W'(8388607);
    localparam logic signed [SHR_W-1:0] SAT_MIN  = SHR_W'(-8388608);

    // Round half-up from Q4.44 back to Q2.22, then clamp to the 24-bit range.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] rnd;
        logic signed [SHR_W-1:0] shr;
        rnd = acc + RND_HALF;
        shr = SHR_W'(rnd >>> FRAC_W);
        if (shr > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (shr < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return shr[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/opti_biquad.sv
// One registered Direct Form I second-order section with valid handshake
// and a synchronous clear of its delay line.
module opti_biquad
    import opti_pkg::*;
#(
    parameter int SEC = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     vld_i,
    input  logic signed [DATA_W-1:0] x_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     vld_o
);

    logic signed [DATA_W-1:0] x1_q, x2_q, y1_q, y2_q, y_q;
    logic                     vld_q;
    logic signed [PROD_W-1:0] p0, p1, p2, p3, p4;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] y_d;

    // Full-precision products and sum; the only rounding happens in round_sat.
    always_comb begin
        p0  = PROD_W'(COEF[SEC][0]) * PROD_W'(x_i);
        p1  = PROD_W'(COEF[SEC][1]) * PROD_W'(x1_q);
        p2  = PROD_W'(COEF[SEC][2]) * PROD_W'(x2_q);
        p3  = PROD_W'(COEF[SEC][3]) * PROD_W'(y1_q);
        p4  = PROD_W'(COEF[SEC][4]) * PROD_W'(y2_q);
        acc = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2) - ACC_W'(p3) - ACC_W'(p4);
        y_d = round_sat(acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q  <= '0;
            x2_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
        end else if (clr_i) begin
            x1_q  <= '0;
            x2_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                x1_q <= x_i;
                x2_q <= x1_q;
                y1_q <= y_d;
                y2_q <= y1_q;
                y_q  <= y_d;
            end
        end
    end

    assign y_o   = y_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/opti_top.sv
// IIR low-pass filter top: run-control FSM, address/output counters, input
// register, NUM_SECTIONS cascaded biquads and an output register.
module opti_top
    import opti_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_in_valid,
    output logic                     filter_done,
    output logic [ADDR_W-1:0]        addr,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_out_valid,
    output logic                     stable_out
);

    state_e                   state_q, state_d;
    logic [INIT_W-1:0]        init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W-1:0]        out_cnt_q, out_cnt_d;
    logic                     done_q, done_d;
    logic                     stable_q;
    logic signed [DATA_W-1:0] in_q;
    logic                     in_vld_q;
    logic signed [DATA_W-1:0] dout_q;
    logic                     dout_vld_q;
    logic                     pipeline_en;
    logic                     accept;
    logic                     clr;
    logic                     out_fire;

    logic signed [DATA_W-1:0] sec_x [NUM_SECTIONS+1];
    logic [NUM_SECTIONS:0]    sec_v;

    assign pipeline_en = (state_q == ST_RUN);
    assign accept      = data_in_valid & pipeline_en;
    assign clr         = (state_q == ST_INIT);
    // Anything still leaving the last section while INIT clears is discarded.
    assign out_fire    = sec_v[NUM_SECTIONS] & ~clr;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        addr_d     = addr_q;
        out_cnt_d  = out_cnt_q;
        done_d     = done_q;
        if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        if (out_fire) begin
            out_cnt_d = out_cnt_q + ADDR_W'(1);
        end
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    addr_d     = '0;
                    out_cnt_d  = '0;
                    done_d     = 1'b0;
                end
            end
            ST_INIT: begin
                addr_d    = '0;
                out_cnt_d = '0;
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_RUN: begin
                if (out_fire && (out_cnt_q == ADDR_W'(N_SAMPLES - 1))) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            addr_q     <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            stable_q   <= 1'b0;
            in_q       <= '0;
            in_vld_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            addr_q     <= addr_d;
            out_cnt_q  <= out_cnt_d;
            done_q     <= done_d;
            stable_q   <= (state_d == ST_RUN);
            in_vld_q   <= accept;
            if (accept) begin
                in_q <= data_in;
            end
            dout_vld_q <= out_fire;
            if (out_fire) begin
                dout_q <= sec_x[NUM_SECTIONS];
            end
        end
    end

    assign sec_x[0] = in_q;
    assign sec_v[0] = in_vld_q;

    for (genvar k = 0; k < NUM_SECTIONS; k++) begin : g_sec
        opti_biquad #(.SEC(k)) u_sec (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr),
            .vld_i (sec_v[k]),
            .x_i   (sec_x[k]),
            .y_o   (sec_x[k+1]),
            .vld_o (sec_v[k+1])
        );
    end

    assign filter_done    = done_q;
    assign addr           = addr_q;
    assign data_out       = dout_q;
    assign data_out_valid = dout_vld_q;
    assign stable_out     = stable_q;

endmodule

// File: tb/tb_opti_top.sv
// Randomised scoreboard bench for opti_top against a floating-free integer
// model of the cascaded biquad equations.
module tb_opti_top;
    import opti_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     start = 1'b0;
    logic signed [DATA_W-1:0] data_in = '0;
    logic                     data_in_valid = 1'b0;
    logic                     filter_done;
    logic [ADDR_W-1:0]        addr;
    logic signed [DATA_W-1:0] data_out;
    logic                     data_out_valid;
    logic                     stable_out;

    opti_top dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .filter_done    (filter_done),
        .addr           (addr),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .stable_out     (stable_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint d;
        int     c;
        bit     last;
    } exp_t;

    exp_t   expq[$];
    int     n_vec = 0;
    int     n_err = 0;
    longint xh [NUM_SECTIONS][2];
    longint yh [NUM_SECTIONS][2];
    logic signed [DATA_W-1:0] stim [N_SAMPLES];

    function automatic void check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endfunction

    function automatic longint clamp24(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NUM_SECTIONS; k++) begin
            xh[k][0] = 0; xh[k][1] = 0; yh[k][0] = 0; yh[k][1] = 0;
        end
    endfunction

    // y = b0*x + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2], rounded and clamped per section.
    function automatic longint model_step(input longint x);
        longint s, acc, y;
        s = x;
        for (int k = 0; k < NUM_SECTIONS; k++) begin
            acc = longint'(COEF[k][0]) * s + longint'(COEF[k][1]) * xh[k][0]
                + longint'(COEF[k][2]) * xh[k][1] - longint'(COEF[k][3]) * yh[k][0]
                - longint'(COEF[k][4]) * yh[k][1];
            y = clamp24((acc + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W);
            xh[k][1] = xh[k][0]; xh[k][0] = s;
            yh[k][1] = yh[k][0]; yh[k][0] = y;
            s = y;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && data_out_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = expq.pop_front();
                check("data_out", data_out, e.d);
                check("latency", cyc - e.c, NUM_SECTIONS + 1);
                check("done_with_last", filter_done, e.last);
            end
        end
    end

    function automatic void fill(input int pat);
        for (int i = 0; i < N_SAMPLES; i++) begin
            case (pat)
                0: stim[i] = '0;
                1: stim[i] = (i == 0) ? 24'sh400000 : '0;
                2: stim[i] = (i < 200) ? 24'sh7FFFFF : DATA_W'($urandom);
                3: stim[i] = ($urandom_range(0, 9) == 0) ? 24'sh800000 : DATA_W'($urandom);
                default: stim[i] = (i < 200) ? 24'sh800000 : DATA_W'($urandom) >>> 3;
            endcase
        end
    endfunction

    task automatic do_start(input bit chk_timing);
        int guard;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
        check("done_cleared_on_start", filter_done, 0);
        if (chk_timing) begin
            repeat (INIT_CYCLES - 1) @(negedge clk);
            check("pipeline_en_in_init", dut.pipeline_en, 0);
            check("stable_in_init", stable_out, 0);
            @(negedge clk);
            check("pipeline_en_rise", dut.pipeline_en, 1);
            check("stable_rise", stable_out, 1);
        end
        guard = 0;
        while (!dut.pipeline_en && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!dut.pipeline_en) check("run_entered", 0, 1);
    endtask

    task automatic feed(input int n, input bit gaps);
        int   i;
        int   guard;
        exp_t e;
        i = 0;
        guard = 0;
        while (i < n && guard < 4 * N_SAMPLES + 100) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                data_in_valid = 1'b0;
                data_in = DATA_W'($urandom);
            end else begin
                data_in = stim[i];
                data_in_valid = 1'b1;
                if (dut.pipeline_en) begin
                    e.d = model_step(longint'(stim[i]));
                    e.c = cyc + 1;
                    e.last = (i == N_SAMPLES - 1);
                    expq.push_back(e);
                    i++;
                end
            end
            @(negedge clk);
            guard++;
        end
        data_in_valid = 1'b0;
        if (i != n) check("feed_timeout", i, n);
    endtask

    task automatic finish_run();
        int guard;
        guard = 0;
        while ((!filter_done || expq.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("filter_done", filter_done, 1);
        check("addr_wrapped", addr, 0);
        check("queue_drained", expq.size(), 0);
        check("stable_low_in_done", stable_out, 0);
    endtask

    task automatic full_run(input int pat, input bit gaps, input bit chk_timing, input bit refill);
        if (refill) fill(pat);
        do_start(chk_timing);
        feed(N_SAMPLES, gaps);
        finish_run();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #50;
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_out_valid, 0);
        check("rst_done", filter_done, 0);
        check("rst_addr", addr, 0);
        check("rst_stable", stable_out, 0);
        #50 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", data_out_valid, 0);
        check("idle_stable", stable_out, 0);
        check("idle_pipeline_en", dut.pipeline_en, 0);

        full_run(0, 1'b0, 1'b1, 1'b1);
        full_run(1, 1'b0, 1'b0, 1'b1);
        full_run(2, 1'b0, 1'b0, 1'b1);
        full_run(3, 1'b0, 1'b0, 1'b1);
        full_run(3, 1'b1, 1'b0, 1'b0);
        full_run(3, 1'b0, 1'b1, 1'b0);
        full_run(4, 1'b1, 1'b0, 1'b1);

        fill(3);
        do_start(1'b0);
        feed(100, 1'b0);
        data_in_valid = 1'b1;
        #2 rst_n = 1'b0;
        expq.delete();
        #1;
        check("midrst_valid", data_out_valid, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_stable", stable_out, 0);
        check("midrst_addr", addr, 0);
        check("midrst_pipeline_en", dut.pipeline_en, 0);
        data_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_stable", stable_out, 0);
        check("post_rst_valid", data_out_valid, 0);

        full_run(3, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
